// File: rtl/proc_pkg.sv
// Shared types and instruction-field helpers for param_proc_core.
// Field offsets are given from bit 0 of a DATA_W-wide instruction word.
package proc_pkg;

   localparam int unsigned OPC_W = 4;

   typedef enum logic [3:0] {
      OP_LOAD  = 4'd0,
      OP_MOV   = 4'd1,
      OP_ADD   = 4'd2,
      OP_SUB   = 4'd3,
      OP_AND   = 4'd4,
      OP_OR    = 4'd5,
      OP_XOR   = 4'd6,
      OP_INV   = 4'd7,
      OP_SHL   = 4'd8,
      OP_SHR   = 4'd9,
      OP_NOP10 = 4'd10,
      OP_NOP11 = 4'd11,
      OP_NOP12 = 4'd12,
      OP_NOP13 = 4'd13,
      OP_NOP14 = 4'd14,
      OP_NOP15 = 4'd15
   } opcode_e;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_e;

   function automatic int unsigned opc_lsb(input int unsigned data_w);
      return data_w - OPC_W;
   endfunction

   function automatic int unsigned rx_lsb(input int unsigned data_w, input int unsigned rw);
      return data_w - OPC_W - rw;
   endfunction

   function automatic int unsigned ry_lsb(input int unsigned data_w, input int unsigned rw);
      return data_w - OPC_W - 2 * rw;
   endfunction

endpackage

// File: rtl/param_proc_core_if.sv
// Instruction handshake, debug peek and status signals of param_proc_core.
// master = instruction source / observer, slave = the core.
interface param_proc_core_if #(
   parameter int unsigned DATA_W = 10,
   parameter int unsigned RW     = 2
);
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] data_in;
   logic [RW-1:0]     peek_addr;
   logic [DATA_W-1:0] peek_data;
   logic [DATA_W-1:0] bus_out;
   logic [1:0]        step;
   logic              done;
   logic              carry;
   logic              zero;

   modport master (
      output instr_valid, data_in, peek_addr,
      input  instr_ready, peek_data, bus_out, step, done, carry, zero
   );

   modport slave (
      input  instr_valid, data_in, peek_addr,
      output instr_ready, peek_data, bus_out, step, done, carry, zero
   );
endinterface

// File: rtl/proc_regfile.sv
// NREGS x DATA_W register file: one write port, two read ports and a debug
// peek port, all reads combinational from the stored state; synchronous clear.
module proc_regfile #(
   parameter int unsigned DATA_W = 10,
   parameter int unsigned NREGS  = 4,
   parameter int unsigned RW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [RW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [RW-1:0]     raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [RW-1:0]     raddr_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic [RW-1:0]     peek_addr,
   output logic [DATA_W-1:0] peek_data
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata_a   = regs_q[raddr_a];
   assign rdata_b   = regs_q[raddr_b];
   assign peek_data = regs_q[peek_addr];

endmodule

// File: rtl/param_proc_core.sv
// Multi-cycle register processor: fetch in T0, single-cycle ops finish in T1,
// ALU ops run A <- rx (T1), G <- A op ry (T2), rx <- G (T3).
module param_proc_core
   import proc_pkg::*;
#(
   parameter int unsigned DATA_W = 10,
   parameter int unsigned NREGS  = 4
) (
   input  logic           CLK,
   input  logic           CLR,
   param_proc_core_if.slave io
);

   localparam int unsigned RW        = $clog2(NREGS);
   localparam int unsigned IR_W      = OPC_W + 2 * RW;
   localparam int unsigned FIELD_LSB = ry_lsb(DATA_W, RW);
   localparam int unsigned IR_OPC    = opc_lsb(DATA_W) - FIELD_LSB;
   localparam int unsigned IR_RX     = rx_lsb(DATA_W, RW) - FIELD_LSB;

   if (DATA_W < 8 || DATA_W > 32) begin : g_bad_data_w
      $error("param_proc_core: DATA_W must be within 8..32");
   end
   if (NREGS < 2 || NREGS > 16 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
      $error("param_proc_core: NREGS must be a power of two within 2..16");
   end
   if (DATA_W < 4 + 2 * RW) begin : g_bad_fields
      $error("param_proc_core: DATA_W too narrow for opcode and register fields");
   end

   state_e            state_q, state_d;
   // Only opcode/rx/ry are kept; the ignored low instruction bits are never stored.
   logic [IR_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] g_q, g_d;
   logic [DATA_W-1:0] bus_q, bus_d;
   logic              carry_q, carry_d;
   logic              zero_q, zero_d;

   opcode_e           opc;
   logic [RW-1:0]     rx, ry;
   logic [DATA_W-1:0] rd_x, rd_y;
   logic              we;
   logic [DATA_W-1:0] wdata;
   logic              done;
   logic [DATA_W:0]   sum, diff;

   assign opc = opcode_e'(ir_q[IR_OPC +: OPC_W]);
   assign rx  = ir_q[IR_RX +: RW];
   assign ry  = ir_q[0 +: RW];

   // Top bit of diff is the borrow out of rx - ry.
   assign sum  = {1'b0, a_q} + {1'b0, rd_y};
   assign diff = {1'b0, a_q} - {1'b0, rd_y};

   proc_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .RW     (RW)
   ) u_regfile (
      .clk       (CLK),
      .clr       (CLR),
      .we        (we),
      .waddr     (rx),
      .wdata     (wdata),
      .raddr_a   (rx),
      .rdata_a   (rd_x),
      .raddr_b   (ry),
      .rdata_b   (rd_y),
      .peek_addr (io.peek_addr),
      .peek_data (io.peek_data)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      a_d     = a_q;
      g_d     = g_q;
      bus_d   = bus_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      we      = 1'b0;
      wdata   = '0;
      done    = 1'b0;

      case (state_q)
         T0: begin
            if (io.instr_valid) begin
               ir_d    = io.data_in[FIELD_LSB +: IR_W];
               state_d = T1;
            end
         end
         T1: begin
            state_d = T0;
            done    = 1'b1;
            we      = 1'b1;
            case (opc)
               OP_LOAD: wdata = io.data_in;
               OP_MOV:  wdata = rd_y;
               OP_INV:  wdata = ~rd_y;
               OP_SHL:  wdata = rd_x << 1;
               OP_SHR:  wdata = rd_x >> 1;
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  a_d     = rd_x;
                  state_d = T2;
                  done    = 1'b0;
                  we      = 1'b0;
               end
               default: we = 1'b0;
            endcase
            if (we) begin
               bus_d = wdata;
            end
         end
         T2: begin
            state_d = T3;
            case (opc)
               OP_ADD: begin
                  g_d     = sum[DATA_W-1:0];
                  carry_d = sum[DATA_W];
                  zero_d  = (sum[DATA_W-1:0] == '0);
               end
               OP_SUB: begin
                  g_d     = diff[DATA_W-1:0];
                  carry_d = ~diff[DATA_W];
                  zero_d  = (diff[DATA_W-1:0] == '0);
               end
               OP_AND:  g_d = a_q & rd_y;
               OP_OR:   g_d = a_q | rd_y;
               OP_XOR:  g_d = a_q ^ rd_y;
               default: g_d = g_q;
            endcase
         end
         T3: begin
            state_d = T0;
            we      = 1'b1;
            wdata   = g_q;
            bus_d   = g_q;
            done    = 1'b1;
         end
         default: state_d = T0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q <= T0;
         ir_q    <= '0;
         a_q     <= '0;
         g_q     <= '0;
         bus_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         g_q     <= g_d;
         bus_q   <= bus_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   assign io.instr_ready = (state_q == T0);
   assign io.step        = state_q;
   assign io.done        = done;
   assign io.bus_out     = bus_q;
   assign io.carry       = carry_q;
   assign io.zero        = zero_q;

endmodule

// File: tb/tb_param_proc_core.sv
// Bench for param_proc_core: vector table, reset corner cases, random
// instructions against an arithmetic model, plus a 16-bit/8-register instance.
module tb_param_proc_core;

   logic clk;
   logic clr;
   int   total;
   int   bad;

   param_proc_core_if #(.DATA_W(10), .RW(2)) ioa ();
   param_proc_core_if #(.DATA_W(16), .RW(3)) iob ();

   param_proc_core #(.DATA_W(10), .NREGS(4)) dut_a (.CLK(clk), .CLR(clr), .io(ioa));
   param_proc_core #(.DATA_W(16), .NREGS(8)) dut_b (.CLK(clk), .CLR(clr), .io(iob));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned m_regs [4];
   int unsigned m_bus;
   bit          m_c;
   bit          m_z;

   typedef struct {
      int unsigned op;
      int unsigned rx;
      int unsigned ry;
      logic [9:0]  imm;
      bit          poke;
      logic [9:0]  exp_rx;
      logic [9:0]  exp_bus;
      bit          exp_c;
      bit          exp_z;
      int unsigned exp_lat;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] enc(input int unsigned op, input int unsigned rx, input int unsigned ry);
      return 10'((op << 6) | (rx << 4) | (ry << 2));
   endfunction

   // Issue one instruction on DUT A; lat counts the accept cycle as 1, 0 on timeout.
   task automatic exec(input logic [9:0] instr, input logic [9:0] imm, input bit poke,
                       output int unsigned lat);
      lat = 0;
      @(negedge clk);
      chk("ready_t0", 32'(ioa.instr_ready), 32'd1);
      ioa.instr_valid = 1'b1;
      ioa.data_in     = instr;
      @(posedge clk); #1;
      ioa.instr_valid = 1'b0;
      ioa.data_in     = imm;
      for (int unsigned c = 2; c <= 8; c++) begin
         @(negedge clk);
         chk("step_seq", 32'(ioa.step), 32'(c - 1));
         chk("ready_busy", 32'(ioa.instr_ready), 32'd0);
         if (ioa.done) begin
            lat = c;
            break;
         end
         if (poke && c == 3) begin
            ioa.instr_valid = 1'b1;
            ioa.data_in     = 10'($urandom);
         end
         @(posedge clk); #1;
         ioa.instr_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("done_pulse_end", 32'(ioa.done), 32'd0);
      chk("step_back_t0", 32'(ioa.step), 32'd0);
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) begin
         ioa.peek_addr = 2'(i);
         #1;
         chk(tag, 32'(ioa.peek_data), m_regs[i]);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) m_regs[i] = 0;
      m_bus = 0;
      m_c   = 1'b0;
      m_z   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      clr = 1'b0;
      model_clear();
   endtask

   // Model: results straight from the opcode table using plain integer arithmetic.
   task automatic run_checked(input int unsigned op, input int unsigned rx, input int unsigned ry,
                              input logic [9:0] imm, input bit poke);
      int unsigned a;
      int unsigned b;
      int unsigned res;
      int unsigned lat_exp;
      int unsigned lat;
      bit          wr;
      a       = m_regs[rx];
      b       = m_regs[ry];
      res     = 0;
      wr      = 1'b1;
      lat_exp = 2;
      case (op)
         0: res = 32'(imm);
         1: res = b;
         2: begin res = a + b; m_c = (res >= 1024); m_z = (res % 1024) == 0; lat_exp = 4; end
         3: begin res = a + 1024 - b; m_c = (a >= b); m_z = (res % 1024) == 0; lat_exp = 4; end
         4: begin res = a & b; lat_exp = 4; end
         5: begin res = a | b; lat_exp = 4; end
         6: begin res = a ^ b; lat_exp = 4; end
         7: res = ~b;
         8: res = a * 2;
         9: res = a / 2;
         default: wr = 1'b0;
      endcase
      res = res % 1024;
      if (wr) begin
         m_regs[rx] = res;
         m_bus      = res;
      end
      exec(enc(op, rx, ry), imm, poke, lat);
      chk("rnd_latency", lat, lat_exp);
      chk("rnd_bus_out", 32'(ioa.bus_out), m_bus);
      chk("rnd_carry", 32'(ioa.carry), 32'(m_c));
      chk("rnd_zero", 32'(ioa.zero), 32'(m_z));
      check_regs("rnd_reg");
   endtask

   initial begin
      int unsigned lat;
      total = 0;
      bad   = 0;
      clr   = 1'b1;
      ioa.instr_valid = 1'b0;
      ioa.data_in     = '0;
      ioa.peek_addr   = '0;
      iob.instr_valid = 1'b0;
      iob.data_in     = '0;
      iob.peek_addr   = '0;
      model_clear();

      //            op rx ry imm    poke exp_rx  exp_bus c  z  lat
      vecs[0]  = '{0, 0, 0, 10'h3FF, 0, 10'h3FF, 10'h3FF, 0, 0, 2};
      vecs[1]  = '{0, 1, 0, 10'h001, 0, 10'h001, 10'h001, 0, 0, 2};
      vecs[2]  = '{2, 0, 1, 10'h000, 0, 10'h000, 10'h000, 1, 1, 4};
      vecs[3]  = '{0, 2, 0, 10'h005, 0, 10'h005, 10'h005, 1, 1, 2};
      vecs[4]  = '{0, 3, 0, 10'h007, 0, 10'h007, 10'h007, 1, 1, 2};
      vecs[5]  = '{3, 2, 3, 10'h000, 1, 10'h3FE, 10'h3FE, 0, 0, 4};
      vecs[6]  = '{4, 2, 3, 10'h000, 0, 10'h006, 10'h006, 0, 0, 4};
      vecs[7]  = '{5, 0, 3, 10'h000, 0, 10'h007, 10'h007, 0, 0, 4};
      vecs[8]  = '{6, 3, 3, 10'h000, 0, 10'h000, 10'h000, 0, 0, 4};
      vecs[9]  = '{7, 3, 2, 10'h000, 0, 10'h3F9, 10'h3F9, 0, 0, 2};
      vecs[10] = '{8, 3, 0, 10'h000, 0, 10'h3F2, 10'h3F2, 0, 0, 2};
      vecs[11] = '{9, 3, 0, 10'h000, 0, 10'h1F9, 10'h1F9, 0, 0, 2};
      vecs[12] = '{1, 1, 3, 10'h000, 0, 10'h1F9, 10'h1F9, 0, 0, 2};
      vecs[13] = '{3, 1, 1, 10'h000, 0, 10'h000, 10'h000, 1, 1, 4};
      vecs[14] = '{2, 3, 3, 10'h000, 0, 10'h3F2, 10'h3F2, 0, 0, 4};
      vecs[15] = '{12, 3, 1, 10'h000, 0, 10'h3F2, 10'h3F2, 0, 0, 2};
      vecs[16] = '{3, 0, 2, 10'h000, 0, 10'h001, 10'h001, 1, 0, 4};

      repeat (3) @(posedge clk);
      #1;
      clr = 1'b0;

      chk("rst_step", 32'(ioa.step), 32'd0);
      chk("rst_ready", 32'(ioa.instr_ready), 32'd1);
      chk("rst_done", 32'(ioa.done), 32'd0);
      chk("rst_bus", 32'(ioa.bus_out), 32'd0);
      chk("rst_carry", 32'(ioa.carry), 32'd0);
      chk("rst_zero", 32'(ioa.zero), 32'd0);
      check_regs("rst_reg");

      for (int i = 0; i < 17; i++) begin
         exec(enc(vecs[i].op, vecs[i].rx, vecs[i].ry), vecs[i].imm, vecs[i].poke, lat);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("vec%0d_bus", i), 32'(ioa.bus_out), 32'(vecs[i].exp_bus));
         chk($sformatf("vec%0d_carry", i), 32'(ioa.carry), 32'(vecs[i].exp_c));
         chk($sformatf("vec%0d_zero", i), 32'(ioa.zero), 32'(vecs[i].exp_z));
         ioa.peek_addr = 2'(vecs[i].rx);
         #1;
         chk($sformatf("vec%0d_rx", i), 32'(ioa.peek_data), 32'(vecs[i].exp_rx));
      end

      // CLR in T2 of an ADD abandons it: no done, no write, everything cleared.
      do_reset();
      run_checked(0, 0, 0, 10'h003, 1'b0);
      run_checked(0, 1, 0, 10'h004, 1'b0);
      @(negedge clk);
      ioa.instr_valid = 1'b1;
      ioa.data_in     = enc(2, 0, 1);
      @(posedge clk); #1;
      ioa.instr_valid = 1'b0;
      @(negedge clk);
      chk("clr_mid_t1_step", 32'(ioa.step), 32'd1);
      chk("clr_mid_t1_done", 32'(ioa.done), 32'd0);
      @(posedge clk); #1;
      clr = 1'b1;
      @(negedge clk);
      chk("clr_mid_t2_step", 32'(ioa.step), 32'd2);
      chk("clr_mid_t2_done", 32'(ioa.done), 32'd0);
      @(posedge clk); #1;
      clr = 1'b0;
      model_clear();
      chk("clr_mid_step", 32'(ioa.step), 32'd0);
      chk("clr_mid_done", 32'(ioa.done), 32'd0);
      chk("clr_mid_bus", 32'(ioa.bus_out), 32'd0);
      chk("clr_mid_carry", 32'(ioa.carry), 32'd0);
      chk("clr_mid_zero", 32'(ioa.zero), 32'd0);
      check_regs("clr_mid_reg");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("clr_mid_no_done", 32'(ioa.done), 32'd0);
         chk("clr_mid_idle", 32'(ioa.step), 32'd0);
      end

      // CLR wins over a same-cycle instr_valid.
      run_checked(0, 2, 0, 10'h2AA, 1'b0);
      @(negedge clk);
      clr             = 1'b1;
      ioa.instr_valid = 1'b1;
      ioa.data_in     = enc(0, 1, 0);
      @(posedge clk); #1;
      clr             = 1'b0;
      ioa.instr_valid = 1'b0;
      model_clear();
      chk("clr_prio_step", 32'(ioa.step), 32'd0);
      chk("clr_prio_ready", 32'(ioa.instr_ready), 32'd1);
      check_regs("clr_prio_reg");
      @(negedge clk);
      chk("clr_prio_idle", 32'(ioa.step), 32'd0);

      for (int n = 0; n < 150; n++) begin
         run_checked($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                     10'($urandom), ($urandom_range(0, 3) == 0));
      end

      // Wide instance: LOAD r5,0xBEEF then XOR r5,r5; peek holds old value until the write.
      iob.peek_addr = 3'd5;
      @(negedge clk);
      iob.instr_valid = 1'b1;
      iob.data_in     = 16'h0A00;
      @(posedge clk); #1;
      iob.instr_valid = 1'b0;
      iob.data_in     = 16'hBEEF;
      @(negedge clk);
      chk("b_load_done", 32'(iob.done), 32'd1);
      chk("b_load_step", 32'(iob.step), 32'd1);
      @(posedge clk); #1;
      chk("b_load_peek", 32'(iob.peek_data), 32'hBEEF);
      chk("b_load_bus", 32'(iob.bus_out), 32'hBEEF);
      @(negedge clk);
      iob.instr_valid = 1'b1;
      iob.data_in     = 16'h6B40;
      @(posedge clk); #1;
      iob.instr_valid = 1'b0;
      iob.data_in     = 16'h0000;
      for (int unsigned c = 2; c <= 4; c++) begin
         @(negedge clk);
         chk("b_xor_peek_hold", 32'(iob.peek_data), 32'hBEEF);
         chk("b_xor_step", 32'(iob.step), 32'(c - 1));
         chk("b_xor_done", 32'(iob.done), (c == 4) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
      end
      chk("b_xor_peek", 32'(iob.peek_data), 32'h0000);
      chk("b_xor_bus", 32'(iob.bus_out), 32'h0000);
      chk("b_xor_step_end", 32'(iob.step), 32'd0);
      chk("b_xor_zero_flag", 32'(iob.zero), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
